// File: rtl/mac_sequencer.sv
// Purpose: time-shares one signed DWxDW multiply-accumulate across NVEC snapshotted vectors, one dot product per vector.
// Latency: first result NELEM+1 cycles after start is taken; each later result NELEM+1 cycles after the previous handshake.
// Backpressure: a pending result is held stable and MAC work stalls until out_ready; start is ignored while busy.
module mac_sequencer #(
    parameter int NVEC  = 4,
    parameter int NELEM = 4,
    parameter int DW    = 8,
    parameter int OUTW  = 16,
    localparam int IW   = (NVEC > 1) ? $clog2(NVEC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NELEM*DW-1:0]       weights,
    input  logic [NVEC*NELEM*DW-1:0]  data,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUTW-1:0]           out_data,
    output logic [IW-1:0]             out_index,
    output logic                      done
);

    // Element counter width and accumulator width. The accumulator is wide
    // enough that NELEM full-precision products can never overflow it, so
    // saturation only ever has to happen once, on the final sum.
    localparam int EW = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int AW = 2*DW + ((NELEM > 1) ? $clog2(NELEM) : 1);

    localparam logic signed [AW-1:0] SAT_MAX = AW'((2**(OUTW-1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2**(OUTW-1)));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    logic [1:0]                 state;
    logic [NELEM*DW-1:0]        w_q;
    logic [NVEC*NELEM*DW-1:0]   d_q;
    logic [IW-1:0]              v_q;
    logic [EW-1:0]              e_q;
    logic signed [AW-1:0]       acc_q;

    logic signed [DW-1:0]       w_sel;
    logic signed [DW-1:0]       d_sel;
    logic signed [2*DW-1:0]     prod;
    logic signed [AW-1:0]       prod_ext;
    logic signed [AW-1:0]       acc_sum;
    logic [OUTW-1:0]            sat_val;
    logic                       last_e;
    logic                       last_v;

    // Operand select from the snapshot registers for the current (v, e) step.
    always_comb begin
        w_sel = $signed(w_q[DW*int'(e_q) +: DW]);
        d_sel = $signed(d_q[DW*(NELEM*int'(v_q) + int'(e_q)) +: DW]);
    end

    // Single shared multiplier; product sign-extended into the accumulator domain.
    always_comb begin
        prod     = w_sel * d_sel;
        prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
        acc_sum  = acc_q + prod_ext;
    end

    // Clamp the running sum including the current product to the output range.
    always_comb begin
        if (acc_sum > SAT_MAX) begin
            sat_val = SAT_MAX[OUTW-1:0];
        end else if (acc_sum < SAT_MIN) begin
            sat_val = SAT_MIN[OUTW-1:0];
        end else begin
            sat_val = acc_sum[OUTW-1:0];
        end
    end

    // End-of-vector and end-of-run markers.
    always_comb begin
        last_e = (e_q == EW'(NELEM-1));
        last_v = (v_q == IW'(NVEC-1));
    end

    // Busy covers both the accumulate and the result-hold phases.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Sequencer: snapshot on start, accumulate one element per cycle, hold each result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            w_q       <= '0;
            d_q       <= '0;
            v_q       <= '0;
            e_q       <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Inputs are captured once here; the run never looks at them again.
                        w_q   <= weights;
                        d_q   <= data;
                        v_q   <= '0;
                        e_q   <= '0;
                        acc_q <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_sum;
                    if (last_e) begin
                        e_q       <= '0;
                        out_data  <= sat_val;
                        out_index <= v_q;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        e_q <= e_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_v) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            v_q   <= v_q + 1'b1;
                            e_q   <= '0;
                            acc_q <= '0;
                            state <= S_MAC;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: directed runs, a per-cycle reference model and
// hand-computed result tables for every run.
module tb_mac_sequencer;

    localparam int NVEC  = 4;
    localparam int NELEM = 4;
    localparam int DW    = 8;
    localparam int OUTW  = 16;
    localparam int IW    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [NELEM*DW-1:0]      weights;
    logic [NVEC*NELEM*DW-1:0] data;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUTW-1:0]          out_data;
    logic [IW-1:0]            out_index;
    logic                     done;

    mac_sequencer #(.NVEC(NVEC), .NELEM(NELEM), .DW(DW), .OUTW(OUTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .weights   (weights),
        .data      (data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int sat_out(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    // ---------------- reference model ----------------
    // State after the most recent rising edge, advanced at each falling edge
    // using the inputs the DUT will sample on the next rising edge.
    bit m_busy, m_valid, m_done;
    int m_data, m_index, m_wait, m_vec;
    int m_res[NVEC];

    int log_data[$];
    int log_idx[$];

    logic            p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
    logic [OUTW-1:0] p_data = '0;
    logic [IW-1:0]   p_idx = '0;

    always @(negedge clk) begin
        n_total++;
        if ($isunknown({busy, out_valid, done, out_data, out_index}) ||
            busy != m_busy || out_valid != m_valid || done != m_done ||
            int'($signed(out_data)) != m_data || int'(out_index) != m_index) begin
            $display("FAIL cycle@%0t: got busy=%b valid=%b done=%b data=%0d idx=%0d, expected busy=%b valid=%b done=%b data=%0d idx=%0d",
                     $time, busy, out_valid, done, $signed(out_data), out_index,
                     m_busy, m_valid, m_done, m_data, m_index);
        end else begin
            n_pass++;
        end

        // A stalled result must not move.
        if (p_valid === 1'b1 && p_ready === 1'b0 && p_rst === 1'b0) begin
            n_total++;
            if (out_valid === 1'b1 && out_data === p_data && out_index === p_idx) n_pass++;
            else $display("FAIL hold@%0t: got valid=%b data=%0d idx=%0d, expected valid=1 data=%0d idx=%0d",
                          $time, out_valid, $signed(out_data), out_index, $signed(p_data), p_idx);
        end
        p_valid = out_valid; p_ready = out_ready; p_rst = rst;
        p_data = out_data; p_idx = out_index;

        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            log_data.push_back(int'($signed(out_data)));
            log_idx.push_back(int'(out_index));
        end

        // Advance the model across the coming rising edge.
        if (rst) begin
            m_busy = 0; m_valid = 0; m_done = 0;
            m_data = 0; m_index = 0; m_wait = 0; m_vec = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    for (int v = 0; v < NVEC; v++) begin
                        int s;
                        s = 0;
                        for (int e = 0; e < NELEM; e++)
                            s += int'($signed(weights[DW*e +: DW])) *
                                 int'($signed(data[DW*(NELEM*v+e) +: DW]));
                        m_res[v] = sat_out(s);
                    end
                    m_busy = 1; m_vec = 0; m_wait = NELEM;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1; m_data = m_res[m_vec]; m_index = m_vec;
                end
            end else if (out_ready) begin
                m_valid = 0;
                if (m_vec < NVEC-1) begin
                    m_vec++; m_wait = NELEM;
                end else begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_w(input int a, input int b, input int c, input int d);
        weights = {8'(d), 8'(c), 8'(b), 8'(a)};
    endtask

    task automatic set_v(input int v, input int a, input int b, input int c, input int d);
        data[DW*NELEM*v +: DW*NELEM] = {8'(d), 8'(c), 8'(b), 8'(a)};
    endtask

    // Edge k counts rising edges after the start-accepting edge (edge 0);
    // outputs are sampled 1 time unit after each edge. A result appearing
    // after edge NELEM is therefore visible in the 5th cycle counting the start cycle.
    task automatic run_case(input int stall_at, input int stall_len, input bit disturb,
                            input int rst_at, output int kv, output int kd, output int nd);
        log_data.delete(); log_idx.delete();
        kv = 0; kd = 0; nd = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 && kv == 0) kv = k;
            if (done === 1'b1) begin
                nd++;
                if (kd == 0) kd = k;
            end
            if (k == stall_at) out_ready = 1'b0;
            if (k == stall_at + stall_len) out_ready = 1'b1;
            if (disturb) begin
                if (k == 1)  start = 1'b1;
                if (k == 3)  data = ~data;
                if (k == 10) start = 1'b0;
            end
            if (rst_at != 0 && k == rst_at) rst = 1'b1;
            if (rst_at != 0 && k == rst_at + 1) begin
                chk("rst_busy", busy, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_done", done, 0);
                rst = 1'b0;
            end
            if (kd != 0 && k >= kd + 4) break;
            if (rst_at != 0 && k >= rst_at + 6) break;
        end
    endtask

    task automatic check_log(input string nm, input int exp[NVEC]);
        chk({nm, "_count"}, log_data.size(), NVEC);
        for (int i = 0; i < NVEC && i < log_data.size(); i++) begin
            chk($sformatf("%s_data%0d", nm, i), log_data[i], exp[i]);
            chk($sformatf("%s_idx%0d", nm, i), log_idx[i], i);
        end
    endtask

    task automatic set_ramp();
        set_w(1, 2, 3, 4);
        for (int v = 0; v < NVEC; v++) set_v(v, v+1, 2*(v+1), 3*(v+1), 4*(v+1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1);
    end

    initial begin
        int kv, kd, nd;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        weights = '0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_data", out_data, 0);
        chk("reset_index", out_index, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All ones times all twos: 4*2 = 8 per vector.
        weights = {NELEM{8'sd1}};
        data    = {(NVEC*NELEM){8'sd2}};
        run_case(0, 0, 1'b0, 0, kv, kd, nd);
        chk("t1_first_valid_edge", kv, 4);
        chk("t1_done_edge", kd, 20);
        chk("t1_done_pulses", nd, 1);
        chk("t1_busy_after", busy, 0);
        check_log("t1", '{8, 8, 8, 8});

        // Signed cancel: 10-10+10-10 = 0.
        set_w(1, -1, 2, -2);
        data = '0;
        set_v(0, 10, 10, 5, 5);
        run_case(0, 0, 1'b0, 0, kv, kd, nd);
        check_log("t2a", '{0, 0, 0, 0});

        // 10 + 0 + 10 + 0 = 20.
        set_v(0, 10, 0, 5, 0);
        run_case(0, 0, 1'b0, 0, kv, kd, nd);
        check_log("t2b", '{20, 0, 0, 0});

        // 4*127*127 = 64516 -> 32767; 4*127*(-128) = -65024 -> -32768; 4*127 = 508.
        weights = {NELEM{8'sd127}};
        set_v(0, 127, 127, 127, 127);
        set_v(1, 0, 0, 0, 0);
        set_v(2, -128, -128, -128, -128);
        set_v(3, 1, 1, 1, 1);
        run_case(0, 0, 1'b0, 0, kv, kd, nd);
        check_log("t3a", '{32767, 0, -32768, 508});

        // 4*(-128)*(-128) = 65536 -> 32767; 4*(-128) = -512; 4*(-128)*127 -> -32768.
        set_w(-128, -128, -128, -128);
        set_v(0, 1, 1, 1, 1);
        set_v(1, -128, -128, -128, -128);
        set_v(2, 127, 127, 127, 127);
        set_v(3, 0, 0, 0, 0);
        run_case(0, 0, 1'b0, 0, kv, kd, nd);
        check_log("t3b", '{-512, 32767, -32768, 0});

        // Ramp: vector v = (v+1)*{1,2,3,4} against {1,2,3,4} gives (v+1)*30.
        // out_ready low on edges 10..16 while result 1 is pending: 7 extra cycles.
        set_ramp();
        run_case(9, 7, 1'b0, 0, kv, kd, nd);
        chk("t4_done_edge", kd, 27);
        chk("t4_done_pulses", nd, 1);
        check_log("t4", '{30, 60, 90, 120});

        // start held across MAC and EMIT, data inverted mid-run: snapshot wins.
        set_ramp();
        run_case(0, 0, 1'b1, 0, kv, kd, nd);
        chk("t5_done_edge", kd, 20);
        chk("t5_done_pulses", nd, 1);
        check_log("t5", '{30, 60, 90, 120});

        // Reset during vector 2 accumulation (rst high at edge 12).
        set_ramp();
        run_case(0, 0, 1'b0, 11, kv, kd, nd);
        chk("t6_done_pulses", nd, 0);
        chk("t6_partial_count", log_data.size(), 2);
        chk("t6_busy_idle", busy, 0);

        // Fresh run after the abort.
        set_w(1, -1, 2, -2);
        data = '0;
        set_v(0, 10, 0, 5, 0);
        set_v(3, -3, 4, 1, 2);
        run_case(0, 0, 1'b0, 0, kv, kd, nd);
        chk("t7_done_pulses", nd, 1);
        check_log("t7", '{20, 0, 0, -9});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
